// File: rtl/afifo_rd_burst_streamer_if.sv
// afifo_rd_burst_streamer_if: FIFO read port plus valid/ready output stream bundle
interface afifo_rd_burst_streamer_if #(parameter int DATA_WIDTH = 64);
  logic fifo_rdreq;
  logic [DATA_WIDTH-1:0] fifo_rddata;
  logic fifo_rdempty;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_last;
  modport master (output fifo_rdreq, m_valid, m_data, m_last, input fifo_rddata, fifo_rdempty, m_ready);
  modport slave (input fifo_rdreq, m_valid, m_data, m_last, output fifo_rddata, fifo_rdempty, m_ready);
endinterface

// File: rtl/afifo_rd_burst_streamer.sv
// afifo_rd_burst_streamer: reads a dual-clock FIFO into a credit-managed buffer and streams whole bursts.
// Define AFIFO_RD_STAT_EN to get a saturating handshake counter on beats_total (tied to 0 otherwise).
module afifo_rd_burst_streamer #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic rdclk,
  input  logic rdrstn,
  input  logic rdsrst,
  input  logic enable,
  afifo_rd_burst_streamer_if.master io,
  output logic busy,
  output logic [$clog2(BUF_DEPTH):0] buf_cnt,
  output logic [31:0] beats_total
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [15:0] LAST = 16'(BURST_LEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [15:0] iss_cnt_q, iss_cnt_d, out_cnt_q, out_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] buf_cnt_q, buf_cnt_d;
  logic [AW+1:0] credit;
  logic inflight_q, inflight_d, busy_q, busy_d;
  logic issue_en, pop;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  always_comb begin
    issue_en = state_q == RUN || (state_q == FLUSH && iss_cnt_q != '0);
    credit = {1'b0, buf_cnt_q} + (AW+2)'(inflight_q);
    // credit counts the beat still in flight so the buffer can never overflow
    io.fifo_rdreq = !rdsrst && issue_en && !io.fifo_rdempty && credit < (AW+2)'(BUF_DEPTH);
    io.m_valid = buf_cnt_q != '0;
    io.m_data = io.m_valid ? mem_q[rd_ptr_q] : '0;
    io.m_last = io.m_valid && out_cnt_q == LAST;
    pop = io.m_valid && io.m_ready;
    inflight_d = io.fifo_rdreq;
    iss_cnt_d = io.fifo_rdreq ? (iss_cnt_q == LAST ? '0 : iss_cnt_q + 16'd1) : iss_cnt_q;
    out_cnt_d = pop ? (out_cnt_q == LAST ? '0 : out_cnt_q + 16'd1) : out_cnt_q;
    wr_ptr_d = wr_ptr_q + AW'(inflight_q);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    buf_cnt_d = buf_cnt_q + (AW+1)'(inflight_q) - (AW+1)'(pop);
    // the stop decision looks at the post-issue count so a burst is never left partial
    unique case (state_q)
      IDLE:    state_d = enable ? RUN : IDLE;
      RUN:     state_d = enable ? RUN : (iss_cnt_d != '0 ? FLUSH : DRAIN);
      FLUSH:   state_d = enable ? RUN : (iss_cnt_d == '0 ? DRAIN : FLUSH);
      default: state_d = enable ? RUN : (!inflight_q && buf_cnt_q == '0 ? IDLE : DRAIN);
    endcase
    if (rdsrst) begin
      state_d = IDLE;
      inflight_d = 1'b0;
      iss_cnt_d = '0;
      out_cnt_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      buf_cnt_d = '0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge rdclk or negedge rdrstn)
    if (!rdrstn) begin
      state_q <= IDLE;
      inflight_q <= 1'b0;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      buf_cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      buf_cnt_q <= buf_cnt_d;
      busy_q <= busy_d;
    end
  always_ff @(posedge rdclk)
    if (inflight_q) mem_q[wr_ptr_q] <= io.fifo_rddata;
  assign busy = busy_q;
  assign buf_cnt = buf_cnt_q;
`ifdef AFIFO_RD_STAT_EN
  logic [31:0] beats_total_q, beats_total_d;
  always_comb beats_total_d = rdsrst ? '0 : beats_total_q + 32'(pop && beats_total_q != '1);
  always_ff @(posedge rdclk or negedge rdrstn)
    if (!rdrstn) beats_total_q <= '0;
    else beats_total_q <= beats_total_d;
  assign beats_total = beats_total_q;
`else
  assign beats_total = '0;
`endif
endmodule
